// File: rtl/calendar_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : calendar_pkg                                             |
// | Brief   : Shared calendar constants, load FSM states, date helpers |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package calendar_pkg;

    localparam logic [6:0] c_JAN = 7'd1;
    localparam logic [6:0] c_FEB = 7'd2;
    localparam logic [6:0] c_MAR = 7'd3;
    localparam logic [6:0] c_APR = 7'd4;
    localparam logic [6:0] c_MAY = 7'd5;
    localparam logic [6:0] c_JUN = 7'd6;
    localparam logic [6:0] c_JUL = 7'd7;
    localparam logic [6:0] c_AUG = 7'd8;
    localparam logic [6:0] c_SEP = 7'd9;
    localparam logic [6:0] c_OCT = 7'd10;
    localparam logic [6:0] c_NOV = 7'd11;
    localparam logic [6:0] c_DEC = 7'd12;

    localparam logic [6:0] c_SUN = 7'd0;
    localparam logic [6:0] c_MON = 7'd1;
    localparam logic [6:0] c_TUE = 7'd2;
    localparam logic [6:0] c_WED = 7'd3;
    localparam logic [6:0] c_THU = 7'd4;
    localparam logic [6:0] c_FRI = 7'd5;
    localparam logic [6:0] c_SAT = 7'd6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIV   = 2'd1,
        S_CHECK = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    // Gregorian rule expressed without a divider: mod400 is tracked separately.
    function automatic logic is_leap(input logic [1:0] year_lo, input logic [8:0] mod400);
        return (year_lo == 2'b00) && (mod400 != 9'd100) &&
               (mod400 != 9'd200) && (mod400 != 9'd300);
    endfunction

    function automatic logic [6:0] days_in_month(input logic [6:0] month, input logic leap);
        logic [6:0] d;
        case (month)
            c_JAN, c_MAR, c_MAY, c_JUL, c_AUG, c_OCT, c_DEC: d = 7'd31;
            c_APR, c_JUN, c_SEP, c_NOV:                      d = 7'd30;
            c_FEB:                                           d = leap ? 7'd29 : 7'd28;
            default:                                         d = 7'd0;
        endcase
        return d;
    endfunction

    function automatic logic [6:0] next_dow(input logic [6:0] dow);
        logic [6:0] n;
        case (dow)
            c_SUN:   n = c_MON;
            c_MON:   n = c_TUE;
            c_TUE:   n = c_WED;
            c_WED:   n = c_THU;
            c_THU:   n = c_FRI;
            c_FRI:   n = c_SAT;
            default: n = c_SUN;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/calendar_counter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : calendar_counter_if                                      |
// | Brief   : Date-load handshake between requester and calendar       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface calendar_counter_if #(
    parameter int YEAR_W = 15
) ();
    logic              load_req;
    logic [YEAR_W-1:0] load_year;
    logic [6:0]        load_month;
    logic [6:0]        load_day;
    logic [6:0]        load_dow;
    logic              load_ack;
    logic              load_err;
    logic              busy;

    modport master (
        output load_req, load_year, load_month, load_day, load_dow,
        input  load_ack, load_err, busy
    );

    modport slave (
        input  load_req, load_year, load_month, load_day, load_dow,
        output load_ack, load_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/year_mod400.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : year_mod400                                              |
// | Brief   : Iterative year mod 400, one subtraction per cycle        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module year_mod400 #(
    parameter int YEAR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [YEAR_W-1:0] year,
    output logic [8:0]        rem,
    output logic              done
);
    localparam logic [YEAR_W-1:0] c_DIVISOR = YEAR_W'(400);

    logic [YEAR_W-1:0] r_rem;
    logic              r_run;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rem <= '0;
            r_run <= 1'b0;
        end else if (start) begin
            r_rem <= year;
            r_run <= 1'b1;
        end else if (r_run) begin
            if (r_rem >= c_DIVISOR) begin
                r_rem <= r_rem - c_DIVISOR;
            end else begin
                r_run <= 1'b0;
            end
        end
    end

    // rem stays stable after done, so the consumer may sample it a cycle later.
    assign done = r_run && (r_rem < c_DIVISOR);
    assign rem  = r_rem[8:0];

endmodule
`default_nettype wire

// File: rtl/calendar_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : calendar_counter                                         |
// | Brief   : Day-granular Gregorian calendar with validated date load |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module calendar_counter
    import calendar_pkg::*;
#(
    parameter int YEAR_W       = 15,
    parameter int RESET_YEAR   = 2000,
    parameter int RESET_DOW    = 6,
    parameter int RESET_MOD400 = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    calendar_counter_if.slave lif,
    output logic [YEAR_W-1:0] year,
    output logic [6:0]        month,
    output logic [6:0]        day,
    output logic [6:0]        day_of_week,
    output logic              leap,
    output logic              month_roll,
    output logic              year_roll,
    output logic              tick_drop
);
    state_t            r_state;
    state_t            w_next;
    logic [YEAR_W-1:0] r_year;
    logic [6:0]        r_month;
    logic [6:0]        r_day;
    logic [6:0]        r_dow;
    logic [8:0]        r_mod400;
    logic [YEAR_W-1:0] r_sh_year;
    logic [6:0]        r_sh_month;
    logic [6:0]        r_sh_day;
    logic [6:0]        r_sh_dow;
    logic              r_err;
    logic              r_month_roll;
    logic              r_year_roll;
    logic              r_tick_drop;

    logic              w_start;
    logic              w_done;
    logic [8:0]        w_rem;
    logic              w_leap;
    logic [6:0]        w_dim;
    logic              w_sh_leap;
    logic [6:0]        w_sh_dim;
    logic              w_sh_valid;
    logic              w_tick_ok;
    logic              w_tick_drop;

    year_mod400 #(.YEAR_W(YEAR_W)) u_mod400 (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .year  (lif.load_year),
        .rem   (w_rem),
        .done  (w_done)
    );

    assign w_leap     = is_leap(r_year[1:0], r_mod400);
    assign w_dim      = days_in_month(r_month, w_leap);
    assign w_sh_leap  = is_leap(r_sh_year[1:0], w_rem);
    assign w_sh_dim   = days_in_month(r_sh_month, w_sh_leap);
    assign w_sh_valid = (r_sh_month >= c_JAN) && (r_sh_month <= c_DEC) &&
                        (r_sh_day != 7'd0) && (r_sh_day <= w_sh_dim) &&
                        (r_sh_dow <= c_SAT);

    // The ACK cycle already holds the committed date, so ticks there are safe.
    assign w_tick_ok   = tick && (((r_state == S_IDLE) && !lif.load_req) || (r_state == S_ACK));
    assign w_tick_drop = tick && !w_tick_ok;

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (lif.load_req) begin
                    w_next  = S_DIV;
                    w_start = 1'b1;
                end
            end
            S_DIV:   if (w_done) w_next = S_CHECK;
            S_CHECK: w_next = S_ACK;
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_year       <= YEAR_W'(RESET_YEAR);
            r_month      <= c_JAN;
            r_day        <= 7'd1;
            r_dow        <= 7'(RESET_DOW);
            r_mod400     <= 9'(RESET_MOD400);
            r_sh_year    <= '0;
            r_sh_month   <= '0;
            r_sh_day     <= '0;
            r_sh_dow     <= '0;
            r_err        <= 1'b0;
            r_month_roll <= 1'b0;
            r_year_roll  <= 1'b0;
            r_tick_drop  <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_month_roll <= 1'b0;
            r_year_roll  <= 1'b0;
            r_tick_drop  <= w_tick_drop;

            if (w_start) begin
                r_sh_year  <= lif.load_year;
                r_sh_month <= lif.load_month;
                r_sh_day   <= lif.load_day;
                r_sh_dow   <= lif.load_dow;
            end

            if (r_state == S_CHECK) begin
                r_err <= !w_sh_valid;
                if (w_sh_valid) begin
                    r_year   <= r_sh_year;
                    r_month  <= r_sh_month;
                    r_day    <= r_sh_day;
                    r_dow    <= r_sh_dow;
                    r_mod400 <= w_rem;
                end
            end else if (w_tick_ok) begin
                r_dow <= next_dow(r_dow);
                if (r_day < w_dim) begin
                    r_day <= r_day + 7'd1;
                end else begin
                    r_day        <= 7'd1;
                    r_month_roll <= 1'b1;
                    if (r_month < c_DEC) begin
                        r_month <= r_month + 7'd1;
                    end else begin
                        r_month     <= c_JAN;
                        r_year_roll <= 1'b1;
                        if (&r_year) begin
                            r_year   <= '0;
                            r_mod400 <= '0;
                        end else begin
                            r_year   <= r_year + YEAR_W'(1);
                            r_mod400 <= (r_mod400 == 9'd399) ? 9'd0 : r_mod400 + 9'd1;
                        end
                    end
                end
            end
        end
    end

    assign lif.load_ack = (r_state == S_ACK);
    assign lif.load_err = (r_state == S_ACK) && r_err;
    assign lif.busy     = (r_state != S_IDLE);

    assign year        = r_year;
    assign month       = r_month;
    assign day         = r_day;
    assign day_of_week = r_dow;
    assign leap        = w_leap;
    assign month_roll  = r_month_roll;
    assign year_roll   = r_year_roll;
    assign tick_drop   = r_tick_drop;

endmodule
`default_nettype wire

// File: tb/tb_calendar_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_calendar_counter                                      |
// | Brief   : Randomised scoreboard bench with an arithmetic date model|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_calendar_counter;
    localparam int YEAR_W   = 15;
    localparam int YEAR_MAX = (1 << YEAR_W) - 1;

    logic              clk  = 1'b0;
    logic              rst  = 1'b0;
    logic              tick = 1'b0;
    logic [YEAR_W-1:0] year;
    logic [6:0]        month;
    logic [6:0]        day;
    logic [6:0]        day_of_week;
    logic              leap;
    logic              month_roll;
    logic              year_roll;
    logic              tick_drop;

    calendar_counter_if #(.YEAR_W(YEAR_W)) lif ();

    calendar_counter #(
        .YEAR_W(YEAR_W), .RESET_YEAR(2000), .RESET_DOW(6), .RESET_MOD400(0)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .lif(lif),
        .year(year), .month(month), .day(day), .day_of_week(day_of_week),
        .leap(leap), .month_roll(month_roll), .year_roll(year_roll),
        .tick_drop(tick_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int year; int month; int day; int dow;
        bit leap; bit mroll; bit yroll; bit drop; bit err; bit chk_date;
    } exp_t;

    exp_t tq[$];
    exp_t lq[$];
    int   total = 0;
    int   bad   = 0;
    int   m_year = 2000, m_month = 1, m_day = 1, m_dow = 6;

    function automatic bit is_leap_yr(int y);
        return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
    endfunction

    function automatic int mdays(int y, int m);
        int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m < 1 || m > 12) return 0;
        if (m == 2 && is_leap_yr(y)) return 29;
        return t[m-1];
    endfunction

    function automatic exp_t mk(bit mr, bit yr, bit dr, bit er, bit cd);
        exp_t e;
        e.year = m_year; e.month = m_month; e.day = m_day; e.dow = m_dow;
        e.leap = is_leap_yr(m_year);
        e.mroll = mr; e.yroll = yr; e.drop = dr; e.err = er; e.chk_date = cd;
        return e;
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_dut(string tag, exp_t e);
        chk({tag, "_year"},  int'(year),        e.year);
        chk({tag, "_month"}, int'(month),       e.month);
        chk({tag, "_day"},   int'(day),         e.day);
        chk({tag, "_dow"},   int'(day_of_week), e.dow);
        chk({tag, "_leap"},  int'(leap),        int'(e.leap));
    endtask

    task automatic chk_now(string tag, int y, int mo, int d, int w);
        chk({tag, "_year"},  int'(year),        y);
        chk({tag, "_month"}, int'(month),       mo);
        chk({tag, "_day"},   int'(day),         d);
        chk({tag, "_dow"},   int'(day_of_week), w);
    endtask

    task automatic model_reset();
        m_year = 2000; m_month = 1; m_day = 1; m_dow = 6;
    endtask

    task automatic model_tick(output bit mr, output bit yr);
        mr = 1'b0; yr = 1'b0;
        m_dow = (m_dow + 1) % 7;
        if (m_day < mdays(m_year, m_month)) begin
            m_day++;
        end else begin
            m_day = 1; mr = 1'b1;
            if (m_month < 12) m_month++;
            else begin
                m_month = 1; yr = 1'b1;
                m_year = (m_year == YEAR_MAX) ? 0 : m_year + 1;
            end
        end
    endtask

    task automatic push_tick();
        bit mr, yr;
        model_tick(mr, yr);
        tq.push_back(mk(mr, yr, 1'b0, 1'b0, 1'b1));
    endtask

    task automatic push_drop();
        tq.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    endtask

    // Monitor: checks each tick's effect one cycle later and every load_ack.
    logic tick_seen = 1'b0;
    always @(posedge clk) tick_seen <= tick && rst;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (tick_seen) begin
                if (tq.size() == 0) begin
                    chk("tick_unexpected", int'(tick_seen), 0);
                end else begin
                    e = tq.pop_front();
                    chk("tick_drop",  int'(tick_drop),  int'(e.drop));
                    chk("month_roll", int'(month_roll), int'(e.mroll));
                    chk("year_roll",  int'(year_roll),  int'(e.yroll));
                    if (e.chk_date) chk_dut("tick", e);
                end
            end else begin
                chk("idle_pulses", int'({month_roll, year_roll, tick_drop}), 0);
            end
            if (lif.load_ack) begin
                if (lq.size() == 0) begin
                    chk("ack_unexpected", int'(lif.load_ack), 0);
                end else begin
                    e = lq.pop_front();
                    chk("load_err", int'(lif.load_err), int'(e.err));
                    chk_dut("load", e);
                end
            end
        end
    end

    task automatic do_ticks(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick = 1'b1;
            push_tick();
        end
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic rand_ticks(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick = ($urandom % 2) == 1;
            if (tick) push_tick();
        end
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic do_load(int y, int mo, int d, int w, bit t_acc, bit t_busy, bit t_ack,
                           output int busy_cycles);
        bit valid;
        bit got;
        valid = (mo >= 1) && (mo <= 12) && (d >= 1) && (d <= mdays(y, mo)) && (w <= 6);
        if (valid) begin
            m_year = y; m_month = mo; m_day = d; m_dow = w;
        end
        lq.push_back(mk(1'b0, 1'b0, 1'b0, !valid, 1'b1));
        @(negedge clk);
        lif.load_year  = YEAR_W'(y);
        lif.load_month = 7'(mo);
        lif.load_day   = 7'(d);
        lif.load_dow   = 7'(w);
        lif.load_req   = 1'b1;
        tick = t_acc;
        if (t_acc) push_drop();
        busy_cycles = 0;
        got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            tick = 1'b0;
            if (lif.load_ack) begin
                got = 1'b1;
                lif.load_req = 1'b0;
                if (t_ack) begin
                    tick = 1'b1;
                    push_tick();
                end
            end else begin
                if (lif.busy) busy_cycles++;
                if (t_busy && ($urandom % 2) == 1) begin
                    tick = 1'b1;
                    push_drop();
                end
            end
        end
        chk("load_ack_seen", int'(got), 1);
        if (!got) begin
            lif.load_req = 1'b0;
            void'(lq.pop_back());
        end
        @(negedge clk);
        tick = 1'b0;
        chk("busy_after_ack", int'(lif.busy), 0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int bc;
        lif.load_req = 1'b0; lif.load_year = '0; lif.load_month = '0;
        lif.load_day = '0;   lif.load_dow  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk_now("reset", 2000, 1, 1, 6);
        chk("reset_leap", int'(leap), 1);
        chk("reset_busy", int'(lif.busy), 0);
        chk("reset_ack",  int'(lif.load_ack), 0);

        // Leap February then month crossing.
        do_ticks(59);
        chk_now("t1_feb29", 2000, 2, 29, 2);
        do_ticks(1);
        chk_now("t1_mar1", 2000, 3, 1, 3);
        chk("t1_month_roll", int'(month_roll), 1);

        do_load(1900, 2, 28, 3, 1'b0, 1'b0, 1'b0, bc);
        chk("t2_leap1900", int'(leap), 0);
        do_ticks(1);
        chk_now("t2_mar1", 1900, 3, 1, 4);

        do_load(2023, 12, 31, 0, 1'b0, 1'b0, 1'b0, bc);
        do_ticks(1);
        chk_now("t3_newyear", 2024, 1, 1, 1);
        chk("t3_year_roll",  int'(year_roll), 1);
        chk("t3_month_roll", int'(month_roll), 1);
        chk("t3_leap", int'(leap), 1);

        do_load(2023, 2, 29, 3, 1'b0, 1'b0, 1'b0, bc);
        do_load(2023, 13, 1, 0, 1'b0, 1'b0, 1'b0, bc);
        do_load(2023, 5, 0, 0, 1'b0, 1'b0, 1'b0, bc);
        do_load(2023, 4, 31, 0, 1'b0, 1'b0, 1'b0, bc);
        do_load(2023, 5, 5, 7, 1'b0, 1'b0, 1'b0, bc);
        do_load(1900, 2, 29, 0, 1'b0, 1'b0, 1'b0, bc);
        chk_now("t4_unchanged", 2024, 1, 1, 1);
        do_load(2400, 2, 29, 2, 1'b0, 1'b0, 1'b0, bc);
        chk("t4_leap2400", int'(leap), 1);

        // Tick in the ACK cycle acts on the freshly committed date.
        do_load(2024, 2, 28, 3, 1'b0, 1'b0, 1'b1, bc);
        chk_now("ack_tick", 2024, 2, 29, 4);

        do_load(YEAR_MAX, 6, 15, 1, 1'b0, 1'b1, 1'b0, bc);
        chk("t5_busy_long", int'(bc >= 81), 1);
        do_load(YEAR_MAX, 12, 31, 4, 1'b0, 1'b1, 1'b0, bc);
        do_ticks(1);
        chk_now("t5_wrap", 0, 1, 1, 5);
        chk("t5_leap0", int'(leap), 1);
        chk("t5_year_roll", int'(year_roll), 1);

        // Reset in the middle of the divide loop: no commit, no ack.
        @(negedge clk);
        lif.load_year = YEAR_W'(YEAR_MAX); lif.load_month = 7'd6;
        lif.load_day = 7'd1; lif.load_dow = 7'd0;
        lif.load_req = 1'b1;
        repeat (10) @(negedge clk);
        chk("t6_busy_mid", int'(lif.busy), 1);
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("t6_busy_rst", int'(lif.busy), 0);
        lif.load_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk_now("t6_reset_date", 2000, 1, 1, 6);
        repeat (100) @(negedge clk);
        chk("t6_idle", int'(lif.busy), 0);

        do_load(2010, 7, 4, 0, 1'b1, 1'b0, 1'b0, bc);
        chk_now("t6_committed", 2010, 7, 4, 0);

        for (int it = 0; it < 40; it++) begin
            int y, mo, d, w;
            y  = ($urandom % 4 == 0) ? YEAR_MAX - int'($urandom_range(0, 2))
                                     : int'($urandom_range(0, YEAR_MAX));
            mo = ($urandom % 3 == 0) ? ((($urandom % 2) == 1) ? 12 : 2)
                                     : int'($urandom_range(0, 13));
            d  = ($urandom % 2 == 0) ? int'($urandom_range(26, 32))
                                     : int'($urandom_range(0, 32));
            w  = int'($urandom_range(0, 7));
            do_load(y, mo, d, w, ($urandom % 4) == 0, ($urandom % 2) == 1,
                    ($urandom % 3) == 0, bc);
            rand_ticks(int'($urandom_range(0, 150)));
        end

        repeat (3) @(negedge clk);
        chk("tick_queue_drained", tq.size(), 0);
        chk("load_queue_drained", lq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/calendar_counter.md
Name: calendar_counter

Overview:
Parametrised day-granular calendar. Advances year/month/day/day-of-week by one day per `tick` and applies the full Gregorian leap rule, so 29 Feb is handled. A load handshake sets an arbitrary date: a multi-cycle FSM derives year mod 400 and then validates the date. Drives the watch date display and the alarm/date comparators. It is fed by the time-of-day block's midnight pulse.

Parameters:
YEAR_W, 15, year counter width (max year 2^YEAR_W-1)
RESET_YEAR, 2000, year after reset
RESET_DOW, 6, day of week after reset (0=Sun..6=Sat; 2000-01-01 is Saturday)
RESET_MOD400, 0, RESET_YEAR mod 400 (must be consistent with RESET_YEAR)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
tick  in  1  advance one day (single-cycle pulse)
load_req  in  1  request to load a date; held with data until load_ack
load_year  in  YEAR_W  date to load
load_month  in  7  1..12
load_day  in  7  1..31
load_dow  in  7  0..6
load_ack  out  1  one-cycle pulse: load finished (accepted or rejected)
load_err  out  1  valid with load_ack: 1 = date rejected, state unchanged
busy  out  1  load FSM not idle
year  out  YEAR_W  current year
month  out  7  current month 1..12
day  out  7  current day 1..31
day_of_week  out  7  0..6
leap  out  1  current year is a leap year
month_roll  out  1  one-cycle pulse: the last tick crossed into a new month
year_roll  out  1  one-cycle pulse: the last tick crossed into a new year
tick_drop  out  1  one-cycle pulse: a tick arrived while busy and was discarded

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-low. All state is sampled on posedge clk only.
- Reset values:
  - year=RESET_YEAR, month=1, day=1, day_of_week=RESET_DOW, mod400=RESET_MOD400.
  - FSM=IDLE; all pulses and busy=0.
- Leap rule: leap = (year[1:0]==0) && (mod400 not in {100,200,300}). The internal 9-bit mod400 register tracks year mod 400. No combinational divide.
- Days in month:
  - 31 for months 1,3,5,7,8,10,12.
  - 30 for months 4,6,9,11.
  - Feb: 29 if leap, else 28.
- Tick in IDLE (all registers update at the same edge):
  - day_of_week = (dow==6) ? 0 : dow+1.
  - If day < days-in-month: day+1.
  - Else: day=1 and month_roll=1.
    - month<12: month+1.
    - month==12: month=1, year+1, mod400 = (mod400==399) ? 0 : mod400+1, year_roll=1.
- Year wrap: at year = 2^YEAR_W-1, year-end wraps year to 0 and sets mod400=0.
- Roll pulses are registered: asserted for exactly the cycle after the crossing edge.
- FSM states: IDLE, DIV, CHECK, ACK.
  - IDLE: load_req=1 moves to DIV and copies load_* into shadow registers; rem = load_year; busy=1.
  - DIV: one subtraction per cycle; while rem >= 400, rem -= 400. When rem < 400, go to CHECK. Worst case ceil((2^YEAR_W-1)/400) cycles (82 for YEAR_W=15).
  - CHECK: compute the shadow leap flag from shadow year[1:0] and rem. Reject if any of: month 0 or >12; day 0 or > days-in-month(shadow); dow >6.
    - Valid: commit year/month/day/dow and mod400=rem.
    - Go to ACK.
  - ACK: load_ack=1 with load_err for one cycle; busy=0 in the next cycle. Go to IDLE.
- Handshake rules:
  - The requester holds load_req until it sees load_ack, then deasserts.
  - A load_req still high in the cycle after ACK starts a new load.
- Simultaneous events:
  - tick while busy, or in the same cycle load_req is accepted: the tick is discarded and tick_drop=1. The committed date wins.
  - tick in the ACK cycle is processed against the newly committed date.
- Reset mid-load aborts to IDLE with no commit and no ack.
- load_req during rst=0 is ignored.

Decomposition:
- Shared package `calendar_pkg`:
  - month constants JAN..DEC.
  - DOW constants SUN..SAT.
  - FSM state typedef.
  - function days_in_month(month, leap).
- Natural sub-module: `year_mod400`. It holds the DIV loop (start, year in; rem, done out) and is reusable by a future day-of-week calculator.

Test Plan:
1. Reset → 2000-01-01, dow=6, leap=1. 59 ticks → 2000-02-29, dow=2; one more tick → 03-01, month_roll=1.
2. Load 1900-02-28 dow=3 → ack, err=0, leap=0. Tick → 1900-03-01, dow=4.
3. Load 2023-12-31 dow=0 → ack, err=0. Tick → 2024-01-01, dow=1, year_roll=1, month_roll=1, leap=1.
4. Load 2023-02-29 → ack with err=1; date unchanged. Load month=13 → err=1. Load day=0 → err=1.
5. Load year 32767: busy holds ≥81 cycles; ticks during busy → tick_drop each, date unchanged. After load 32767-12-31, tick → year=0, mod400=0, leap=1.
6. Assert rst=0 mid-DIV → back to reset date; no load_ack. Tick and load_req in the same cycle → tick_drop=1, loaded date committed.
